fc_train_sequencer: RTL and testbench

//  Sequences one N-wide ternary-tree fully-connected network: accepts a sample (input + target),

---
 rtl/fc_train_sequencer_if.sv | 54 +++++
 rtl/fc_train_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fc_train_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fc_train_sequencer_if.sv
// Sample-side, fc-side and result-side signals of fc_train_sequencer in one bundle.
// FC_SEQ_TIMEOUT_EN adds timeout_out.
interface fc_train_sequencer_if #(
  parameter int unsigned N  = 27,
  parameter int unsigned CW = 16
);
  localparam int unsigned EW = $clog2(N + 1);

  logic          s_valid_in;
  logic          s_ready_out;
  logic [N-1:0]  s_data_in;
  logic [N-1:0]  s_target_in;
  logic          s_train_in;
  logic [N-1:0]  fc_fin_out;
  logic [N-1:0]  fc_bin_out;
  logic          fc_fd_prop_out;
  logic          fc_bk_prop_out;
  logic          fc_oscillator_out;
  logic          fc_fd_done_in;
  logic          fc_bk_done_in;
  logic [N-1:0]  fc_fout_in;
  logic          m_valid_out;
  logic          m_ready_in;
  logic [N-1:0]  m_data_out;
  logic [EW-1:0] m_err_count_out;
  logic [CW-1:0] sample_count_out;
  logic          busy_out;
`ifdef FC_SEQ_TIMEOUT_EN
  logic          timeout_out;
`endif

  // master: the sequencer; slave: sample source, fc network and result sink.
  modport master (
    input  s_valid_in, s_data_in, s_target_in, s_train_in,
    input  fc_fd_done_in, fc_bk_done_in, fc_fout_in, m_ready_in,
    output s_ready_out, fc_fin_out, fc_bin_out, fc_fd_prop_out, fc_bk_prop_out,
    output fc_oscillator_out, m_valid_out, m_data_out, m_err_count_out,
`ifdef FC_SEQ_TIMEOUT_EN
    output timeout_out,
`endif
    output sample_count_out, busy_out
  );

  modport slave (
    output s_valid_in, s_data_in, s_target_in, s_train_in,
    output fc_fd_done_in, fc_bk_done_in, fc_fout_in, m_ready_in,
    input  s_ready_out, fc_fin_out, fc_bin_out, fc_fd_prop_out, fc_bk_prop_out,
    input  fc_oscillator_out, m_valid_out, m_data_out, m_err_count_out,
`ifdef FC_SEQ_TIMEOUT_EN
    input  timeout_out,
`endif
    input  sample_count_out, busy_out
  );
endinterface

// File: rtl/fc_train_sequencer.sv
// Sequences forward (and in training, backward) propagation of one fc network per sample.
// Optional FC_SEQ_TIMEOUT_EN bounds the wait for each done pulse to TIMEOUT cycles.
module fc_train_sequencer #(
  parameter int unsigned N       = 27,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input logic                  clk_in,
  input logic                  rst_in,
  fc_train_sequencer_if.master bus
);
  localparam int unsigned EW = $clog2(N + 1);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StFwd, StFwdWait, StBwd, StBwdWait, StOut} state_e;

  state_e        state_q;
  logic [N-1:0]  fin_q, bin_q, target_q, mdata_q;
  logic          train_q, ready_q, fd_q, bk_q, osc_q, mvalid_q, busy_q;
  logic [EW-1:0] errcnt_q;
  logic [CW-1:0] count_q;
  logic [N-1:0]  err;
  logic [EW-1:0] err_pop;

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q;
  logic          timeout_q;
  logic          expired;
  assign expired         = (cnt_q == TW'(TIMEOUT - 1));
  assign bus.timeout_out = timeout_q;
`endif

  always_comb begin
    err     = bus.fc_fout_in ^ target_q;
    err_pop = '0;
    for (int i = 0; i < N; i++) begin
      err_pop = err_pop + EW'(err[i]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      fin_q    <= '0;
      bin_q    <= '0;
      target_q <= '0;
      mdata_q  <= '0;
      train_q  <= 1'b0;
      ready_q  <= 1'b0;
      fd_q     <= 1'b0;
      bk_q     <= 1'b0;
      osc_q    <= 1'b0;
      mvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      errcnt_q <= '0;
      count_q  <= '0;
`ifdef FC_SEQ_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      fd_q <= 1'b0;
      bk_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Ready comes up one cycle after reset release, then stays up while idle.
          ready_q <= 1'b1;
          if (bus.s_valid_in && ready_q) begin
            fin_q    <= bus.s_data_in;
            target_q <= bus.s_target_in;
            train_q  <= bus.s_train_in;
            bin_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            fd_q     <= 1'b1;
            state_q  <= StFwd;
          end
        end
        StFwd: begin
          state_q <= StFwdWait;
`ifdef FC_SEQ_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        StFwdWait: begin
`ifdef FC_SEQ_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          if (bus.fc_fd_done_in) begin
            mdata_q  <= bus.fc_fout_in;
            errcnt_q <= err_pop;
            if (train_q) begin
              bin_q   <= err;
              bk_q    <= 1'b1;
              state_q <= StBwd;
            end else begin
              mvalid_q <= 1'b1;
              state_q  <= StOut;
            end
          end
`ifdef FC_SEQ_TIMEOUT_EN
          else if (expired) begin
            mdata_q   <= '0;
            errcnt_q  <= EW'(N);
            timeout_q <= 1'b1;
            mvalid_q  <= 1'b1;
            state_q   <= StOut;
          end
`endif
        end
        StBwd: begin
          state_q <= StBwdWait;
`ifdef FC_SEQ_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        StBwdWait: begin
`ifdef FC_SEQ_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          if (bus.fc_bk_done_in) begin
            osc_q    <= ~osc_q;
            mvalid_q <= 1'b1;
            state_q  <= StOut;
          end
`ifdef FC_SEQ_TIMEOUT_EN
          else if (expired) begin
            mdata_q   <= '0;
            errcnt_q  <= EW'(N);
            timeout_q <= 1'b1;
            mvalid_q  <= 1'b1;
            state_q   <= StOut;
          end
`endif
        end
        StOut: begin
          if (bus.m_ready_in) begin
            mvalid_q <= 1'b0;
            count_q  <= count_q + 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= StIdle;
`ifdef FC_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_ready_out       = ready_q;
  assign bus.fc_fin_out        = fin_q;
  assign bus.fc_bin_out        = bin_q;
  assign bus.fc_fd_prop_out    = fd_q;
  assign bus.fc_bk_prop_out    = bk_q;
  assign bus.fc_oscillator_out = osc_q;
  assign bus.m_valid_out       = mvalid_q;
  assign bus.m_data_out        = mdata_q;
  assign bus.m_err_count_out   = errcnt_q;
  assign bus.sample_count_out  = count_q;
  assign bus.busy_out          = busy_q;
endmodule

// File: tb/tb_fc_train_sequencer.sv
// Directed bench for fc_train_sequencer; the bench plays sample source, fc network and sink.
module tb_fc_train_sequencer;
  localparam int unsigned N  = 27;
  localparam int unsigned CW = 16;
`ifdef FC_SEQ_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_train_sequencer_if #(.N(N), .CW(CW)) bus ();

  fc_train_sequencer #(.N(N), .TIMEOUT(TO), .CW(CW)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [N-1:0] data;
    logic [N-1:0] target;
    logic [N-1:0] fout;
    bit           train;
    logic [N-1:0] exp_bin;
    logic [4:0]   exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int bk_cnt = 0;
  int exp_cnt = 0;
  bit exp_osc = 1'b0;

  always @(negedge clk) begin
    if (bus.fc_fd_prop_out) fd_cnt++;
    if (bus.fc_bk_prop_out) bk_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [N-1:0] d, input logic [N-1:0] t, input bit tr);
    int n = 0;
    while (!bus.s_ready_out && n < 50) begin @(negedge clk); n++; end
    if (!bus.s_ready_out) check("s_ready_timeout", 32'd0, 32'd1);
    bus.s_valid_in = 1'b1; bus.s_data_in = d; bus.s_target_in = t; bus.s_train_in = tr;
    @(negedge clk);
    bus.s_valid_in = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    while (!bus.fc_fd_prop_out && n < 20) begin @(negedge clk); n++; end
    if (!bus.fc_fd_prop_out) check("fd_pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic fc_forward(input logic [N-1:0] f);
    repeat (3) @(negedge clk);
    bus.fc_fd_done_in = 1'b1; bus.fc_fout_in = f;
    @(negedge clk);
    bus.fc_fd_done_in = 1'b0;
  endtask

  task automatic fc_backward();
    int n = 0;
    while (!bus.fc_bk_prop_out && n < 20) begin @(negedge clk); n++; end
    if (!bus.fc_bk_prop_out) check("bk_pulse_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.fc_bk_done_in = 1'b1;
    @(negedge clk);
    bus.fc_bk_done_in = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.m_valid_out && n < 50) begin @(negedge clk); n++; end
    if (!bus.m_valid_out) check("m_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept();
    bus.m_ready_in = 1'b1;
    @(negedge clk);
    bus.m_ready_in = 1'b0;
    exp_cnt++;
  endtask

  vec_t vecs[4];

  initial begin
    logic [N-1:0] held;
    int           bad_v, bad_d, bad_r, bad_f, fd0, bk0, n;
    bit           osc0;

    bus.s_valid_in = 0; bus.s_data_in = '0; bus.s_target_in = '0; bus.s_train_in = 0;
    bus.fc_fd_done_in = 0; bus.fc_bk_done_in = 0; bus.fc_fout_in = '0; bus.m_ready_in = 0;

    vecs[0] = '{data: 27'h5,   target: 27'h5,       fout: 27'h5,   train: 0,
                exp_bin: 27'h0, exp_err: 5'd0};
    vecs[1] = '{data: 27'h9,   target: 27'h7,       fout: 27'h4,   train: 1,
                exp_bin: 27'h3, exp_err: 5'd2};
    vecs[2] = '{data: 27'h1AB, target: 27'h123,     fout: 27'h123, train: 1,
                exp_bin: 27'h0, exp_err: 5'd0};
    vecs[3] = '{data: 27'h3,   target: 27'h7FFFFFF, fout: 27'h0,   train: 0,
                exp_bin: 27'h0, exp_err: 5'd27};

    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 32'(bus.s_ready_out), 32'd1);

    foreach (vecs[i]) begin
      fd0 = fd_cnt; bk0 = bk_cnt;
      send(vecs[i].data, vecs[i].target, vecs[i].train);
      check($sformatf("v%0d_busy", i), 32'(bus.busy_out), 32'd1);
      wait_fd();
      check($sformatf("v%0d_fin", i), 32'(bus.fc_fin_out), 32'(vecs[i].data));
      fc_forward(vecs[i].fout);
      if (vecs[i].train) fc_backward();
      wait_valid();
      exp_osc ^= vecs[i].train;
      check($sformatf("v%0d_mdata", i), 32'(bus.m_data_out), 32'(vecs[i].fout));
      check($sformatf("v%0d_errcnt", i), 32'(bus.m_err_count_out), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_bin", i), 32'(bus.fc_bin_out), 32'(vecs[i].exp_bin));
      check($sformatf("v%0d_osc", i), 32'(bus.fc_oscillator_out), 32'(exp_osc));
      accept();
      check($sformatf("v%0d_count", i), 32'(bus.sample_count_out), 32'(exp_cnt));
      check($sformatf("v%0d_idle", i), 32'(bus.busy_out), 32'd0);
      check($sformatf("v%0d_fd_pulses", i), 32'(fd_cnt - fd0), 32'd1);
      check($sformatf("v%0d_bk_pulses", i), 32'(bk_cnt - bk0), 32'(vecs[i].train));
    end

    // Reset while waiting for the forward done.
    send(27'h15, 27'h2A, 1'b1);
    wait_fd();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy_out), 32'd0);
    check("midrst_fin", 32'(bus.fc_fin_out), 32'd0);
    check("midrst_mdata", 32'(bus.m_data_out), 32'd0);
    check("midrst_count", 32'(bus.sample_count_out), 32'd0);
    check("midrst_osc", 32'(bus.fc_oscillator_out), 32'd0);
    check("midrst_s_ready", 32'(bus.s_ready_out), 32'd0);
    exp_cnt = 0; exp_osc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fd0 = fd_cnt; bk0 = bk_cnt;
    repeat (3) @(negedge clk);
    check("rel_s_ready", 32'(bus.s_ready_out), 32'd1);
    check("rel_no_pulse", 32'((fd_cnt - fd0) + (bk_cnt - bk0)), 32'd0);

    // Backpressure: result held, new samples ignored.
    send(27'h11, 27'h0F, 1'b0);
    wait_fd();
    fc_forward(27'h0C);
    wait_valid();
    held = bus.m_data_out;
    check("bp_mdata", 32'(held), 32'h0C);
    bus.s_valid_in = 1'b1; bus.s_data_in = 27'h777;
    bad_v = 0; bad_d = 0; bad_r = 0; bad_f = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_valid_out !== 1'b1) bad_v++;
      if (bus.m_data_out !== held) bad_d++;
      if (bus.s_ready_out !== 1'b0) bad_r++;
      if (bus.fc_fin_out !== 27'h11) bad_f++;
    end
    check("bp_valid_held", 32'(bad_v), 32'd0);
    check("bp_data_held", 32'(bad_d), 32'd0);
    check("bp_not_ready", 32'(bad_r), 32'd0);
    check("bp_fin_kept", 32'(bad_f), 32'd0);
    bus.s_valid_in = 1'b0;
    accept();
    check("bp_released", 32'(bus.m_valid_out), 32'd0);
    check("bp_idle", 32'(bus.s_ready_out), 32'd1);
    check("bp_count", 32'(bus.sample_count_out), 32'(exp_cnt));

    // Spurious done pulses in IDLE and in FWD_WAIT.
    osc0 = bus.fc_oscillator_out; bk0 = bk_cnt;
    bus.fc_bk_done_in = 1'b1; bus.fc_fd_done_in = 1'b1;
    @(negedge clk);
    bus.fc_bk_done_in = 1'b0; bus.fc_fd_done_in = 1'b0;
    @(negedge clk);
    check("spur_idle_busy", 32'(bus.busy_out), 32'd0);
    check("spur_idle_valid", 32'(bus.m_valid_out), 32'd0);
    send(27'h2, 27'h6, 1'b1);
    wait_fd();
    @(negedge clk);
    bus.fc_bk_done_in = 1'b1;
    @(negedge clk);
    bus.fc_bk_done_in = 1'b0;
    @(negedge clk);
    check("spur_fw_busy", 32'(bus.busy_out), 32'd1);
    check("spur_fw_valid", 32'(bus.m_valid_out), 32'd0);
    check("spur_fw_osc", 32'(bus.fc_oscillator_out), 32'(osc0));
    check("spur_fw_bk", 32'(bk_cnt - bk0), 32'd0);
    fc_forward(27'h3);
    fc_backward();
    wait_valid();
    check("spur_errcnt", 32'(bus.m_err_count_out), 32'd2);
    check("spur_bin", 32'(bus.fc_bin_out), 32'h5);
    accept();

`ifdef FC_SEQ_TIMEOUT_EN
    // fd done never arrives: 8 FWD_WAIT cycles, so m_valid is seen on the 9th negedge
    // after the one that saw the fd pulse.
    send(27'h1, 27'h1, 1'b0);
    wait_fd();
    n = 0;
    while (!bus.m_valid_out && n < 100) begin @(negedge clk); n++; end
    check("to_cycles", 32'(n), 32'd9);
    check("to_flag", 32'(bus.timeout_out), 32'd1);
    check("to_errcnt", 32'(bus.m_err_count_out), 32'd27);
    check("to_mdata", 32'(bus.m_data_out), 32'd0);
    accept();
    check("to_flag_clr", 32'(bus.timeout_out), 32'd0);
`else
    n = 0;
`endif
    check("final_count", 32'(bus.sample_count_out), 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
